// File: rtl/wbuf_pkg.sv
// rtl/wbuf_pkg.sv - shared bank state encoding and default geometry for the weight ping-pong buffer
package wbuf_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    localparam int DEF_ARRAY_WIDTH = 4;
    localparam int DEF_DATA_SIZE   = 8;
    localparam int DEF_DEPTH       = 4;
    localparam int ROW_W           = DEF_ARRAY_WIDTH * DEF_DATA_SIZE;

    // A bank "holds a tile" once it is complete and until its last row leaves.
    function automatic logic holds_tile(input bank_state_t s);
        return (s == BANK_FULL) || (s == BANK_DRAINING);
    endfunction

    function automatic logic accepts_rows(input bank_state_t s);
        return (s == BANK_EMPTY) || (s == BANK_FILLING);
    endfunction

endpackage

// File: rtl/weight_bank.sv
// rtl/weight_bank.sv - DEPTH-row register file, one synchronous write port and one combinational read port
module weight_bank #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // No reset on storage: the top gates the read data with out_valid.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/weight_pingpong_buffer.sv
// rtl/weight_pingpong_buffer.sv - double-buffered weight tile stager; WBUF_REVERSE_EN drains rows last-loaded-first
module weight_pingpong_buffer
    import wbuf_pkg::*;
#(
    parameter int ARRAY_WIDTH = DEF_ARRAY_WIDTH,
    parameter int DATA_SIZE   = DEF_DATA_SIZE,
    parameter int DEPTH       = DEF_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic [ARRAY_WIDTH*DATA_SIZE-1:0] in_weight,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ARRAY_WIDTH*DATA_SIZE-1:0] out_weight,
    output logic                             tile_done,
    output logic [1:0]                       full_banks
);

    localparam int RW = ARRAY_WIDTH * DATA_SIZE;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

    bank_state_t state_q [2];
    bank_state_t state_d [2];

    logic          wr_bank;
    logic          rd_bank;
    logic [AW-1:0] wr_row;
    logic [AW-1:0] rd_row;
    logic [AW-1:0] raddr;
    logic [RW-1:0] rdata0;
    logic [RW-1:0] rdata1;

    logic load_fire;
    logic load_last;
    logic drain_fire;
    logic drain_last;

    assign load_ready = accepts_rows(state_q[wr_bank]);
    assign out_valid  = holds_tile(state_q[rd_bank]);

    // flush wins over any same-cycle handshake, so neither side advances.
    assign load_fire  = load_valid && load_ready && !flush;
    assign load_last  = load_fire && (wr_row == LAST_ROW);
    assign drain_fire = out_valid && out_ready && !flush;
    assign drain_last = drain_fire && (rd_row == LAST_ROW);

`ifdef WBUF_REVERSE_EN
    assign raddr = LAST_ROW - rd_row;
`else
    assign raddr = rd_row;
`endif

    weight_bank #(
        .DEPTH (DEPTH),
        .WIDTH (RW),
        .AW    (AW)
    ) u_bank0 (
        .clk   (clk),
        .we    (load_fire && !wr_bank),
        .waddr (wr_row),
        .wdata (in_weight),
        .raddr (raddr),
        .rdata (rdata0)
    );

    weight_bank #(
        .DEPTH (DEPTH),
        .WIDTH (RW),
        .AW    (AW)
    ) u_bank1 (
        .clk   (clk),
        .we    (load_fire && wr_bank),
        .waddr (wr_row),
        .wdata (in_weight),
        .raddr (raddr),
        .rdata (rdata1)
    );

    assign out_weight = out_valid ? (rd_bank ? rdata1 : rdata0) : '0;

    // Load and drain never target the same bank in one cycle: their state sets are disjoint.
    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        for (int b = 0; b < 2; b++) begin
            if (flush) begin
                state_d[b] = BANK_EMPTY;
            end else begin
                if (load_fire && (wr_bank == b[0])) begin
                    state_d[b] = load_last ? BANK_FULL : BANK_FILLING;
                end
                if (drain_fire && (rd_bank == b[0])) begin
                    state_d[b] = drain_last ? BANK_EMPTY : BANK_DRAINING;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_row     <= '0;
            rd_row     <= '0;
            tile_done  <= 1'b0;
            full_banks <= 2'd0;
        end else if (flush) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_row     <= '0;
            rd_row     <= '0;
            tile_done  <= 1'b0;
            full_banks <= 2'd0;
        end else begin
            tile_done  <= drain_last;
            full_banks <= {1'b0, holds_tile(state_d[0])} + {1'b0, holds_tile(state_d[1])};
            if (load_fire) begin
                if (load_last) begin
                    wr_row  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_row  <= wr_row + 1'b1;
                end
            end
            if (drain_fire) begin
                if (drain_last) begin
                    rd_row  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_row  <= rd_row + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// tb/tb_weight_pingpong_buffer.sv - scoreboard bench for weight_pingpong_buffer (honours WBUF_REVERSE_EN)
module tb_weight_pingpong_buffer;

    localparam int ARRAY_WIDTH = 4;
    localparam int DATA_SIZE   = 8;
    localparam int DEPTH       = 4;
    localparam int RW          = ARRAY_WIDTH * DATA_SIZE;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          load_valid;
    logic          load_ready;
    logic [RW-1:0] in_weight;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_weight;
    logic          tile_done;
    logic [1:0]    full_banks;

    always #5 clk = ~clk;

    weight_pingpong_buffer #(
        .ARRAY_WIDTH (ARRAY_WIDTH),
        .DATA_SIZE   (DATA_SIZE),
        .DEPTH       (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .in_weight  (in_weight),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_weight (out_weight),
        .tile_done  (tile_done),
        .full_banks (full_banks)
    );

    int            passed = 0;
    int            total  = 0;
    logic [RW-1:0] sb [$];
    logic [RW-1:0] tile_buf [$];
    logic [RW-1:0] mon_exp;
    int            beats  = 0;
    logic          td_exp = 1'b0;
    logic          mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Lane i of row r in tile t holds 0x40*t + 0x10*r + i (tile 0 matches 0x03020100...).
    function automatic logic [RW-1:0] mkrow(input int t, input int r);
        logic [RW-1:0] v;
        for (int i = 0; i < ARRAY_WIDTH; i++) v[i*DATA_SIZE +: DATA_SIZE] = 8'(64*t + 16*r + i);
        return v;
    endfunction

    task automatic record(input logic [RW-1:0] d);
        tile_buf.push_back(d);
        if (tile_buf.size() == DEPTH) begin
`ifdef WBUF_REVERSE_EN
            for (int i = DEPTH - 1; i >= 0; i--) sb.push_back(tile_buf[i]);
`else
            for (int i = 0; i < DEPTH; i++) sb.push_back(tile_buf[i]);
`endif
            tile_buf.delete();
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_row(input logic [RW-1:0] d);
        logic acc;
        acc = 1'b0;
        load_valid = 1'b1;
        in_weight  = d;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = load_ready;
            tick();
        end
        if (acc) record(d);
        else check("load_timeout", 0, 1);
    endtask

    task automatic wait_drain;
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !out_valid;
            tick();
        end
        if (!done) check("drain_timeout", 0, 1);
        out_ready = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every accepted drain beat and tracks tile_done.
    always @(negedge clk) begin
        if (mon_en) begin
            check("tile_done", tile_done, td_exp);
            td_exp = 1'b0;
            if (!out_valid) begin
                check("out_weight_gated", out_weight, 0);
            end else if (out_ready && !flush && rst) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_row: got %0h expected none", out_weight);
                end else begin
                    mon_exp = sb.pop_front();
                    check("drain_row", out_weight, mon_exp);
                end
                beats++;
                if (beats == DEPTH) begin
                    beats  = 0;
                    td_exp = 1'b1;
                end
            end
        end
    end

    initial begin
        logic seen;
        rst        = 1'b0;
        flush      = 1'b0;
        load_valid = 1'b0;
        in_weight  = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_load_ready", load_ready, 1);
            check("idle_out_valid", out_valid, 0);
            check("idle_full_banks", full_banks, 0);
        end
        tick();

        // One tile, held off the array, then drained
        for (int r = 0; r < DEPTH; r++) load_row(mkrow(0, r));
        load_valid = 1'b0;
        @(negedge clk);
        check("tile_full_banks", full_banks, 1);
        check("tile_out_valid", out_valid, 1);
        check("tile_load_ready", load_ready, 1);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("drain_consecutive", out_valid, 1);
        end
        @(negedge clk);
        check("drain_end_out_valid", out_valid, 0);
        tick();
        out_ready = 1'b0;

        // Three tiles back-to-back with the array stalled
        for (int t = 1; t <= 2; t++)
            for (int r = 0; r < DEPTH; r++) load_row(mkrow(t, r));
        in_weight = mkrow(3, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("both_full_banks", full_banks, 2);
            check("ninth_held_off", load_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("load_ready_return", load_ready, (k == 5));
            if (k < 5) tick();
        end
        tick();
        record(mkrow(3, 0));
        for (int r = 1; r < DEPTH; r++) load_row(mkrow(3, r));
        load_valid = 1'b0;
        wait_drain();

        // Continuous streaming: no bubbles on out_valid across four tiles
        out_ready = 1'b1;
        fork
            begin
                for (int t = 0; t < 4; t++)
                    for (int r = 0; r < DEPTH; r++) load_row(mkrow(t, r));
                load_valid = 1'b0;
            end
            begin
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                check("stream_first_valid", seen, 1);
                for (int j = 0; j < 4*DEPTH - 1; j++) begin
                    @(negedge clk);
                    check("stream_no_bubble", out_valid, 1);
                end
            end
        join
        wait_drain();

        // Clear mid-fill and mid-drain, first by flush then by reset
        for (int use_rst = 0; use_rst < 2; use_rst++) begin
            load_row(mkrow(1, 0));
            load_row(mkrow(1, 1));
            load_valid = 1'b0;
            if (use_rst == 1) rst = 1'b0;
            else flush = 1'b1;
            tile_buf.delete();
            tick();
            rst   = 1'b1;
            flush = 1'b0;
            @(negedge clk);
            check("clr_fill_out_valid", out_valid, 0);
            check("clr_fill_full_banks", full_banks, 0);
            check("clr_fill_load_ready", load_ready, 1);
            tick();

            for (int r = 0; r < DEPTH; r++) load_row(mkrow(2, r));
            load_valid = 1'b0;
            out_ready  = 1'b1;
            @(negedge clk);
            @(negedge clk);
            tick();
            out_ready = 1'b0;
            if (use_rst == 1) rst = 1'b0;
            else flush = 1'b1;
            sb.delete();
            beats = 0;
            tick();
            rst   = 1'b1;
            flush = 1'b0;
            @(negedge clk);
            check("clr_drain_out_valid", out_valid, 0);
            check("clr_drain_full_banks", full_banks, 0);
            check("clr_drain_load_ready", load_ready, 1);
            tick();

            for (int r = 0; r < DEPTH; r++) load_row(mkrow(3, r));
            load_valid = 1'b0;
            out_ready  = 1'b1;
            wait_drain();
        end

        repeat (2) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/weight_pingpong_buffer.md
# weight_pingpong_buffer

Double-buffered weight staging buffer between the weight load port and the systolic array's weight preload path. It accepts a tile of DEPTH weight rows, each ARRAY_WIDTH lanes wide, into one bank while the other bank drains rows into the array. The drain strobe doubles as the array's `write_weight_en`. It generalises the single-bank weight buffer in three ways: parametrised depth, ping-pong banking, and valid/ready flow control on both sides.

## Interface
Parameters:
- ARRAY_WIDTH, 4, lanes per row (array columns)
- DATA_SIZE, 8, bits per weight
- DEPTH, 4, rows per tile (array height); must be ≥ 2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of both banks and all pointers
- load_valid  in  1  in_weight row is valid
- load_ready  out  1  fill bank can accept a row
- in_weight  in  ARRAY_WIDTH*DATA_SIZE  one weight row; lane 0 in the LSBs
- out_valid  out  1  out_weight row is valid; drives the array's write_weight_en
- out_ready  in  1  array accepts the row
- out_weight  out  ARRAY_WIDTH*DATA_SIZE  drained row; zero whenever out_valid=0
- tile_done  out  1  one-cycle pulse after the last row of a tile is accepted
- full_banks  out  2  number of banks holding a complete tile (0..2)

## Operation
- Two banks, each DEPTH × ARRAY_WIDTH*DATA_SIZE registers. Per-bank state is EMPTY → FILLING → FULL → DRAINING → EMPTY.
- Write pointer wr_bank and read pointer rd_bank are each 1 bit. Row counters are $clog2(DEPTH) bits.
- Load side:
  - load_ready = state[wr_bank] ∈ {EMPTY, FILLING}.
  - On load_valid && load_ready: write the row at wr_row, then increment wr_row.
  - When wr_row = DEPTH-1 is written: bank goes FULL, wr_row → 0, wr_bank toggles.
- Drain side:
  - out_valid = state[rd_bank] ∈ {FULL, DRAINING}.
  - out_weight = bank[rd_bank][row_index(rd_row)].
  - On out_valid && out_ready: increment rd_row and set the bank to DRAINING.
  - On the last row: bank goes EMPTY, rd_row → 0, rd_bank toggles, tile_done pulses the next cycle.
- Loading one bank and draining the other in the same cycle is legal and independent.
- A bank freed by its final drain beat becomes visible to load_ready on the following cycle. There is no same-cycle bypass.
- If load_valid is held while load_ready=0, the row is not written; the producer must hold it.
- flush: all states go EMPTY, pointers and counters go 0, tile_done=0. Register contents are not cleared, because the output is gated. flush has priority over same-cycle load and drain.
- Reset mid-tile: identical to flush, but asynchronous.

## Timing
- Reset values: load_ready=1, out_valid=0, out_weight=0, tile_done=0, full_banks=0.
- Load-to-drain latency: if the last row of a tile is accepted at edge N, out_valid=1 from edge N onward (visible in cycle N+1).
- Drain throughput: one row per cycle while out_ready=1. A tile takes DEPTH cycles.
- Back-to-back tiles with the second bank already FULL: zero bubble between tiles at the drain side.
- Load side sustains one row per cycle while a bank is free. It stalls for one cycle minimum when both banks are occupied and a drain completes.
- tile_done is registered and lasts exactly one cycle.
- full_banks is registered and counts banks in FULL or DRAINING.

## Configuration
- WBUF_REVERSE_EN defined: row_index(r) = DEPTH-1-r. The last-loaded row drains first, matching top-down shift preload where the bottom PE row must receive its weight first.
- WBUF_REVERSE_EN undefined: row_index(r) = r, so rows drain in FIFO order.
- Handshake timing is identical either way.

## Structure
- Shared package wbuf_pkg holds:
  - the bank state encoding (2-bit enum: EMPTY, FILLING, FULL, DRAINING);
  - defaults for ARRAY_WIDTH, DATA_SIZE and DEPTH;
  - the ROW_W = ARRAY_WIDTH*DATA_SIZE localparam.
- Sub-module weight_bank: one DEPTH-row register file with a write port (we, waddr, wdata) and a combinational read port (raddr, rdata). The buffer instantiates it twice.
- The top level holds the pointers, the per-bank state FSMs, the counters, output gating and tile_done.

## Test plan
All cases use ARRAY_WIDTH=4, DATA_SIZE=8, DEPTH=4.
- Reset then idle → load_ready=1, out_valid=0, out_weight=0, full_banks=0 for 10 cycles.
- Load rows 0x03020100, 0x13121110, 0x23222120, 0x33323130 with out_ready=0 → full_banks=1 and out_valid=1 on the next cycle, load_ready still 1.
- Then raise out_ready:
  - with WBUF_REVERSE_EN → rows 0x33323130…0x03020100 on 4 consecutive cycles, then a single tile_done pulse;
  - without it → order 0x03020100…0x33323130.
- Load 3 tiles back-to-back with out_ready=0 → load_ready drops after the 8th row and the 9th row is held off. After one drained tile, load_ready returns the cycle after the final drain beat.
- Continuous streaming with out_ready=1 and load_valid=1 → 0 bubbles on out_valid across 4 tiles. Every row matches, with no loss or duplication.
- Assert flush (and, in a separate run, rst=0) after 2 rows of a tile and mid-drain → next cycle out_valid=0, full_banks=0, load_ready=1. The next full tile drains correctly from row index 0.
